// File: rtl/spike_packet_sender.sv
// spike_packet_sender: Wishbone master that sends one image's spike packets.
// A header write (image_spike_event_o high) carries the packet count N, then
// N packet writes are drained from an internal FIFO, one beat at a time.
//
// Ports:
//   wb_clk_i, wb_rst_n_i        clock, asynchronous active-low reset
//   start_i, num_packets_i      begin an image with N packets (IDLE only)
//   push_i, push_data_i, full_o packet FIFO write side and full flag
//   busy_o, done_o              not-IDLE status, one-cycle completion pulse
//   sent_count_o                packets acknowledged in the current image
//   image_spike_event_o         high while the header beat is on the bus
//   wbm_*                       Wishbone master (cyc/stb/we/adr/dat/sel, ack in)
module spike_packet_sender #(
    parameter int unsigned FIFO_DEPTH = 16,
    parameter logic [31:0] HDR_ADDR   = 32'h3000_0000,
    parameter logic [31:0] PKT_ADDR   = 32'h3000_0004
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_n_i,
    input  logic        start_i,
    input  logic [7:0]  num_packets_i,
    input  logic        push_i,
    input  logic [31:0] push_data_i,
    output logic        full_o,
    output logic        busy_o,
    output logic        done_o,
    output logic [7:0]  sent_count_o,
    output logic        image_spike_event_o,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    output logic [3:0]  wbm_sel_o,
    input  logic        wbm_ack_i
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned PW = AW + 1;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_HDR  = 3'd1,
        S_WAIT = 3'd2,
        S_PKT  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t state, state_next;

    // Packet FIFO
    logic [31:0]   mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr, wr_ptr_next, rd_ptr_next;
    logic          empty, push_ok, pop;
    logic [31:0]   head;

    // Image bookkeeping and next values of the registered outputs
    logic [7:0]  n_q, n_next, count_next;
    logic        busy_next, done_next, ise_next, beat_next;
    logic [31:0] adr_next, dat_next;
    logic [3:0]  sel_next;

    // A push while full is dropped, even when a pop happens in the same cycle
    assign push_ok     = push_i && !full_o;
    assign empty       = (wr_ptr == rd_ptr);
    assign head        = mem[rd_ptr[AW-1:0]];
    assign wr_ptr_next = wr_ptr + PW'(push_ok);
    assign rd_ptr_next = rd_ptr + PW'(pop);

    // FIFO storage; contents need no reset because the pointers define validity
    always_ff @(posedge wb_clk_i) begin
        if (push_ok) begin
            mem[wr_ptr[AW-1:0]] <= push_data_i;
        end
    end

    // FIFO pointers and registered full flag
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            full_o <= 1'b0;
        end else begin
            wr_ptr <= wr_ptr_next;
            rd_ptr <= rd_ptr_next;
            full_o <= ((wr_ptr_next - rd_ptr_next) == PW'(FIFO_DEPTH));
        end
    end

    // State register
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state, FIFO pop, and next values for every registered output
    always_comb begin
        state_next = state;
        n_next     = n_q;
        count_next = sent_count_o;
        pop        = 1'b0;

        case (state)
            S_IDLE: begin
                if (start_i) begin
                    state_next = S_HDR;
                    n_next     = num_packets_i;
                    count_next = 8'd0;
                end
            end
            S_HDR: begin
                if (wbm_ack_i) begin
                    state_next = (n_q == 8'd0) ? S_DONE : S_WAIT;
                end
            end
            S_WAIT: begin
                if (!empty) begin
                    state_next = S_PKT;
                end
            end
            S_PKT: begin
                if (wbm_ack_i) begin
                    pop        = 1'b1;
                    count_next = 8'(sent_count_o + 8'd1);
                    state_next = (count_next == n_q) ? S_DONE : S_WAIT;
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase

        // Outputs are decoded from the next state so they appear right after the edge
        beat_next = (state_next == S_HDR) || (state_next == S_PKT);
        busy_next = (state_next != S_IDLE);
        done_next = (state_next == S_DONE);
        ise_next  = (state_next == S_HDR);
        adr_next  = 32'd0;
        dat_next  = 32'd0;
        sel_next  = 4'h0;
        if (state_next == S_HDR) begin
            adr_next = HDR_ADDR;
            dat_next = {24'd0, n_next};
            sel_next = 4'hF;
        end else if (state_next == S_PKT) begin
            // Head is stable for the whole beat: no pop happens until the ack
            adr_next = PKT_ADDR;
            dat_next = head;
            sel_next = 4'hF;
        end
    end

    // Registered outputs and image count
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            n_q                 <= 8'd0;
            sent_count_o        <= 8'd0;
            busy_o              <= 1'b0;
            done_o              <= 1'b0;
            image_spike_event_o <= 1'b0;
            wbm_cyc_o           <= 1'b0;
            wbm_stb_o           <= 1'b0;
            wbm_we_o            <= 1'b0;
            wbm_adr_o           <= 32'd0;
            wbm_dat_o           <= 32'd0;
            wbm_sel_o           <= 4'h0;
        end else begin
            n_q                 <= n_next;
            sent_count_o        <= count_next;
            busy_o              <= busy_next;
            done_o              <= done_next;
            image_spike_event_o <= ise_next;
            wbm_cyc_o           <= beat_next;
            wbm_stb_o           <= beat_next;
            wbm_we_o            <= beat_next;
            wbm_adr_o           <= adr_next;
            wbm_dat_o           <= dat_next;
            wbm_sel_o           <= sel_next;
        end
    end

endmodule

// File: tb/tb_spike_packet_sender.sv
// Bench for spike_packet_sender: random packet data and slave wait states,
// a transaction-level reference model feeding an expected-write queue, and a
// negedge monitor that compares every bus beat and status output against it.
module tb_spike_packet_sender;

    localparam logic [31:0] HDR   = 32'h3000_0000;
    localparam logic [31:0] PKT   = 32'h3000_0004;
    localparam int          DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  num = 8'd0;
    logic        push = 1'b0;
    logic [31:0] pdata = 32'd0;
    logic        full_o, busy_o, done_o, image_spike_event_o;
    logic [7:0]  sent_count_o;
    logic        wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_ack_i;
    logic [31:0] wbm_adr_o, wbm_dat_o;
    logic [3:0]  wbm_sel_o;

    int errors = 0;
    int checks = 0;

    // Slave model: ack after wait_states cycles of stb; random ack noise when idle
    int   wait_states = 0;
    int   ack_cnt = 0;
    logic ack_noise = 1'b0;

    spike_packet_sender dut (
        .wb_clk_i            (clk),
        .wb_rst_n_i          (rst_n),
        .start_i             (start),
        .num_packets_i       (num),
        .push_i              (push),
        .push_data_i         (pdata),
        .full_o              (full_o),
        .busy_o              (busy_o),
        .done_o              (done_o),
        .sent_count_o        (sent_count_o),
        .image_spike_event_o (image_spike_event_o),
        .wbm_cyc_o           (wbm_cyc_o),
        .wbm_stb_o           (wbm_stb_o),
        .wbm_we_o            (wbm_we_o),
        .wbm_adr_o           (wbm_adr_o),
        .wbm_dat_o           (wbm_dat_o),
        .wbm_sel_o           (wbm_sel_o),
        .wbm_ack_i           (wbm_ack_i)
    );

    always #5 clk = ~clk;

    assign wbm_ack_i = (wbm_cyc_o && wbm_stb_o) ? (ack_cnt == wait_states) : ack_noise;

    always @(posedge clk) begin
        if (wbm_cyc_o && wbm_stb_o && !wbm_ack_i) ack_cnt <= ack_cnt + 1;
        else                                      ack_cnt <= 0;
        ack_noise <= ($urandom_range(0, 3) == 0);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model state
    typedef struct {
        logic [31:0] adr;
        logic [31:0] dat;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] mfifo[$];
    int occ = 0;
    int need = 0;
    int pend = 0;
    int dcnt = 0;
    int exp_sent = 0;
    int pkt_acks = 0;
    bit active = 1'b0;
    bit prev_ack = 1'b0;

    // Monitor + model: inputs and bus are stable at negedge; effects apply at the next posedge
    always @(negedge clk) begin
        logic beat, hdr_front, final_ack, push_acc;
        exp_t f;
        if (!rst_n) begin
            exp_q.delete();
            mfifo.delete();
            occ = 0; need = 0; pend = 0; dcnt = 0; exp_sent = 0;
            active = 1'b0; prev_ack = 1'b0;
        end else begin
            hdr_front = 1'b0;
            if (exp_q.size() > 0) hdr_front = (exp_q[0].adr == HDR);
            beat = wbm_cyc_o && wbm_stb_o && wbm_ack_i;

            chk("done_o", 32'(done_o), 32'(dcnt == 2));
            chk("busy_o", 32'(busy_o), 32'(active || dcnt == 2));
            chk("full_o", 32'(full_o), 32'(occ == DEPTH));
            chk("sent_count", 32'(sent_count_o), 32'(exp_sent));
            chk("cyc_eq_stb", 32'(wbm_cyc_o), 32'(wbm_stb_o));
            if (prev_ack) chk("cyc_gap_after_ack", 32'(wbm_cyc_o), 32'd0);
            if (exp_q.size() == 0) begin
                chk("spurious_stb", 32'(wbm_stb_o), 32'd0);
            end else if (wbm_stb_o) begin
                chk("beat_adr", wbm_adr_o, exp_q[0].adr);
                chk("beat_dat", wbm_dat_o, exp_q[0].dat);
                chk("beat_we", 32'(wbm_we_o), 32'd1);
                chk("beat_sel", 32'(wbm_sel_o), 32'hF);
            end
            chk("image_spike_event", 32'(image_spike_event_o), 32'(wbm_stb_o && hdr_front));

            push_acc = push && (occ < DEPTH);
            if (dcnt != 0) dcnt--;
            if (beat && exp_q.size() > 0) begin
                f = exp_q.pop_front();
                final_ack = 1'b0;
                if (f.adr == HDR) begin
                    final_ack = (need == 0);
                end else begin
                    need--; occ--; exp_sent++; pkt_acks++;
                    final_ack = (need == 0);
                end
                if (final_ack) begin
                    active = 1'b0;
                    dcnt = 2;
                end
            end
            if (push_acc) begin
                mfifo.push_back(pdata);
                occ++;
            end
            if (start && !active && dcnt == 0) begin
                exp_q.push_back('{adr: HDR, dat: {24'd0, num}});
                need = int'(num);
                pend = int'(num);
                exp_sent = 0;
                active = 1'b1;
            end
            while (pend > 0 && mfifo.size() > 0) begin
                exp_q.push_back('{adr: PKT, dat: mfifo.pop_front()});
                pend--;
            end
            prev_ack = beat;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [31:0] d);
        push = 1'b1;
        pdata = d;
        tick();
        push = 1'b0;
    endtask

    task automatic start_pulse(input logic [7:0] n);
        start = 1'b1;
        num = n;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int b = 0;
        while ((active || dcnt != 0 || pend != 0 || exp_q.size() != 0) && b < budget) begin
            tick();
            b++;
        end
        if (b >= budget) begin
            checks++;
            errors++;
            $display("FAIL wait_idle: image not finished after %0d cycles", budget);
        end
    endtask

    // Start and count cycles from the start edge to the done_o cycle inclusive
    task automatic run_timed(input logic [7:0] n, output int c);
        start_pulse(n);
        c = 1;
        while (!done_o && c < 200) begin
            tick();
            c++;
        end
    endtask

    initial begin
        int c, base, b, k, n, extra;

        repeat (2) tick();
        chk("rst_cyc", 32'(wbm_cyc_o), 32'd0);
        chk("rst_stb", 32'(wbm_stb_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_done", 32'(done_o), 32'd0);
        chk("rst_full", 32'(full_o), 32'd0);
        chk("rst_sent", 32'(sent_count_o), 32'd0);
        chk("rst_adr", wbm_adr_o, 32'd0);
        chk("rst_dat", wbm_dat_o, 32'd0);
        chk("rst_ise", 32'(image_spike_event_o), 32'd0);
        rst_n = 1'b1;
        tick();

        // N = 3, pre-filled FIFO, zero-wait slave
        wait_states = 0;
        for (int i = 0; i < 3; i++) push_word($urandom);
        run_timed(8'd3, c);
        chk("t1_latency", 32'(c), 32'd8);
        chk("t1_sent", 32'(sent_count_o), 32'd3);
        wait_idle(20);

        // N = 0: header only
        run_timed(8'd0, c);
        chk("t2_latency", 32'(c), 32'd2);
        wait_idle(20);

        // N = 2 with late pushes: idles in WAIT with the bus released
        start_pulse(8'd2);
        repeat (9) tick();
        chk("t3_wait_cyc", 32'(wbm_cyc_o), 32'd0);
        chk("t3_wait_busy", 32'(busy_o), 32'd1);
        push_word($urandom);
        repeat (9) tick();
        chk("t3_sent_mid", 32'(sent_count_o), 32'd1);
        push_word($urandom);
        wait_idle(50);
        chk("t3_sent", 32'(sent_count_o), 32'd2);

        // 3 wait states per beat
        wait_states = 3;
        for (int i = 0; i < 3; i++) push_word($urandom);
        start_pulse(8'd3);
        wait_idle(100);
        chk("t4_sent", 32'(sent_count_o), 32'd3);

        // Overfill: 17 pushes into 16 entries, then N = 16 with ignored starts
        wait_states = 0;
        for (int i = 0; i < 17; i++) begin
            push_word($urandom);
            if (i == 14) chk("t5_not_full_15", 32'(full_o), 32'd0);
            if (i == 15) chk("t5_full_16", 32'(full_o), 32'd1);
        end
        chk("t5_full_17", 32'(full_o), 32'd1);
        start_pulse(8'd16);
        for (int i = 0; i < 6; i++) begin
            repeat (3) tick();
            start_pulse(8'($urandom_range(1, 255)));
        end
        wait_idle(200);
        chk("t5_sent", 32'(sent_count_o), 32'd16);

        // Reset during the second packet beat of N = 4
        wait_states = 2;
        for (int i = 0; i < 4; i++) push_word($urandom);
        base = pkt_acks;
        start_pulse(8'd4);
        b = 0;
        while (!(pkt_acks == base + 1 && wbm_stb_o) && b < 100) begin
            tick();
            b++;
        end
        chk("t6_reached_beat2", 32'(pkt_acks - base), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("t6_cyc", 32'(wbm_cyc_o), 32'd0);
        chk("t6_stb", 32'(wbm_stb_o), 32'd0);
        chk("t6_busy", 32'(busy_o), 32'd0);
        chk("t6_done", 32'(done_o), 32'd0);
        chk("t6_ise", 32'(image_spike_event_o), 32'd0);
        chk("t6_adr", wbm_adr_o, 32'd0);
        chk("t6_dat", wbm_dat_o, 32'd0);
        chk("t6_sent", 32'(sent_count_o), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        chk("t6_busy_after", 32'(busy_o), 32'd0);
        chk("t6_full_after", 32'(full_o), 32'd0);
        wait_states = 0;
        push_word($urandom);
        start_pulse(8'd1);
        wait_idle(30);
        chk("t6_sent_after", 32'(sent_count_o), 32'd1);

        // Random images: random wait states, partial pre-fill, late pushes, surplus words
        for (int img = 0; img < 6; img++) begin
            wait_states = $urandom_range(0, 2);
            n = $urandom_range(1, 6);
            k = $urandom_range(0, n);
            extra = $urandom_range(0, 1);
            for (int i = 0; i < k; i++) push_word($urandom);
            start_pulse(8'(n));
            for (int i = 0; i < n - k + extra; i++) begin
                repeat ($urandom_range(0, 4)) tick();
                push_word($urandom);
            end
            wait_idle(300);
        end

        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
